// File: rtl/data_mem.sv
// Word-organised single-port data memory behind the load/store units.
// Clears itself after reset, then serves registered word reads and lane-masked stores.
module data_mem #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        mem_rw_mode,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  store_control,
  input  logic [31:0] store_data,
  output logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  typedef enum logic [2:0] {
    ST_NOP = 3'd0,
    ST_SB  = 3'd1,
    ST_SH  = 3'd2,
    ST_SW  = 3'd3
  } store_op_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic            in_range;
  store_op_t       op;
  logic            align_ok;
  logic            is_store;
  logic            accept_read;
  logic            accept_store;
  logic            reject_store;

  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [31:0]     wr_data;
  logic [3:0]      wr_be;

  assign idx      = mem_addr[AW+1:2];
  assign in_range = (mem_addr[31:AW+2] == '0);

  // Codes 4-7 collapse onto ST_NOP so they can never reach the write path.
  always_comb begin
    case (store_control)
      3'd1:    op = ST_SB;
      3'd2:    op = ST_SH;
      3'd3:    op = ST_SW;
      default: op = ST_NOP;
    endcase
  end

  always_comb begin
    case (op)
      ST_SH:   align_ok = ~mem_addr[0];
      ST_SW:   align_ok = (mem_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  assign is_store     = ~mem_rw_mode && (op != ST_NOP);
  assign accept_read  = (state_q == S_READY) && mem_rw_mode;
  assign accept_store = (state_q == S_READY) && ~i_rst && is_store && in_range && align_ok;
  assign reject_store = (state_q == S_READY) && is_store && in_range && ~align_ok;
  assign mem_ready    = (state_q == S_READY);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  // The clear sequence and accepted stores share the single write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = store_data;
    wr_be   = 4'b0000;
    if (state_q == S_CLEAR && ~i_rst) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt_q;
      wr_data = '0;
      wr_be   = 4'b1111;
    end else if (accept_store) begin
      wr_en = 1'b1;
      case (op)
        ST_SB: begin
          wr_data = {4{store_data[7:0]}};
          wr_be   = 4'b0001 << mem_addr[1:0];
        end
        ST_SH: begin
          wr_data = {2{store_data[15:0]}};
          wr_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wr_data = store_data;
          wr_be   = 4'b1111;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      mem_data   <= '0;
      misaligned <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      misaligned <= reject_store;
      if (accept_read) mem_data <= in_range ? mem[idx] : '0;
    end
  end

  // NOTE: the array has no reset branch; the CLEAR sequence zeroes it so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (wr_be[lane]) mem[wr_idx][8*lane +: 8] <= wr_data[8*lane +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem (DEPTH_WORDS = 256).
module tb_data_mem;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        mem_rw_mode;
  logic [31:0] mem_addr;
  logic [2:0]  store_control;
  logic [31:0] store_data;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        misaligned;

  int checks = 0;
  int errors = 0;
  int n;
  int mis_seen;

  always #5 i_clk = ~i_clk;

  data_mem #(.DEPTH_WORDS(256)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .mem_rw_mode   (mem_rw_mode),
    .mem_addr      (mem_addr),
    .store_control (store_control),
    .store_data    (store_data),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .misaligned    (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [2:0] sc, input logic [31:0] addr,
                       input logic [31:0] data);
    mem_rw_mode   = rw;
    store_control = sc;
    mem_addr      = addr;
    store_data    = data;
  endtask

  task automatic do_idle();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
  endtask

  task automatic do_read(input logic [31:0] addr);
    drive(1'b1, 3'd0, addr, 32'h0);
    step();
  endtask

  task automatic do_store(input logic [2:0] sc, input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, sc, addr, data);
    step();
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!mem_ready && cycles < 1000) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    i_rst = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    i_rst = 1'b0;
    check("rst_mem_data", mem_data, 32'h0);
    check("rst_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'h0);

    // Hammer stores during CLEAR; the last one lands in the completing cycle.
    n = 0;
    mis_seen = 0;
    while (!mem_ready && n < 1000) begin
      if (n % 2 == 1) drive(1'b0, 3'd3, 32'h8, 32'hFFFF_FFFF);
      else            drive(1'b0, 3'd3, 32'h0A, 32'hFFFF_FFFF);
      step();
      n++;
      if (misaligned) mis_seen++;
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("clear_cycles", n, 256);
    check("clear_no_misaligned", mis_seen, 0);

    for (int i = 0; i < 256; i++) begin
      do_read(32'(i * 4));
      check($sformatf("zero_word_%0d", i), mem_data, 32'h0);
    end

    do_store(3'd3, 32'h10, 32'hDEAD_BEEF);
    do_read(32'h10);
    check("sw_read_10", mem_data, 32'hDEAD_BEEF);
    do_store(3'd3, 32'h20, 32'h1122_3344);
    check("hold_during_store", mem_data, 32'hDEAD_BEEF);
    do_read(32'h14);
    check("read_14_zero", mem_data, 32'h0);

    do_store(3'd1, 32'h22, 32'h0000_00AA);
    do_read(32'h20);
    check("sb_lane2", mem_data, 32'h11AA_3344);
    do_store(3'd2, 32'h20, 32'h0000_BEEF);
    do_read(32'h20);
    check("sh_low", mem_data, 32'h11AA_BEEF);
    do_store(3'd2, 32'h22, 32'hFFFF_5566);
    do_store(3'd1, 32'h23, 32'hFFFF_FF77);
    do_read(32'h20);
    check("sh_high_sb_lane3", mem_data, 32'h7766_BEEF);

    do_store(3'd0, 32'h20, 32'h0);
    check("nop_hold", mem_data, 32'h7766_BEEF);
    do_store(3'd5, 32'h20, 32'h0);
    drive(1'b1, 3'd3, 32'h20, 32'h0);
    step();
    check("read_ignores_store", mem_data, 32'h7766_BEEF);
    do_read(32'h20);
    check("nop_no_write", mem_data, 32'h7766_BEEF);

    do_store(3'd3, 32'h30, 32'h0A0B_0C0D);
    check("aligned_no_flag", {31'b0, misaligned}, 32'h0);
    do_store(3'd2, 32'h31, 32'h0000_1234);
    check("sh_mis_flag", {31'b0, misaligned}, 32'h1);
    do_read(32'h30);
    check("sh_mis_drop", {31'b0, misaligned}, 32'h0);
    check("sh_mis_word", mem_data, 32'h0A0B_0C0D);
    do_store(3'd3, 32'h32, 32'h5555_5555);
    check("sw_mis_flag", {31'b0, misaligned}, 32'h1);
    do_read(32'h30);
    check("sw_mis_drop", {31'b0, misaligned}, 32'h0);
    check("sw_mis_word", mem_data, 32'h0A0B_0C0D);
    do_store(3'd2, 32'h33, 32'h0000_9999);
    check("b2b_mis_1", {31'b0, misaligned}, 32'h1);
    do_store(3'd3, 32'h31, 32'h9999_9999);
    check("b2b_mis_2", {31'b0, misaligned}, 32'h1);
    do_read(32'h30);
    check("b2b_mis_end", {31'b0, misaligned}, 32'h0);
    check("b2b_mis_word", mem_data, 32'h0A0B_0C0D);
    do_store(3'd1, 32'h31, 32'h0000_00EE);
    check("sb_odd_no_flag", {31'b0, misaligned}, 32'h0);
    do_read(32'h30);
    check("sb_odd_word", mem_data, 32'h0A0B_EE0D);

    do_store(3'd3, 32'h400, 32'h1234_5678);
    check("oor_sw_no_flag", {31'b0, misaligned}, 32'h0);
    do_store(3'd3, 32'h402, 32'h1234_5678);
    check("oor_mis_no_flag", {31'b0, misaligned}, 32'h0);
    do_read(32'h400);
    check("oor_read_zero", mem_data, 32'h0);
    do_read(32'h0);
    check("word0_unchanged", mem_data, 32'h0);
    do_read(32'h8);
    check("word2_unchanged", mem_data, 32'h0);

    do_store(3'd3, 32'h40, 32'hCAFE_F00D);
    do_read(32'h40);
    check("sw_read_40", mem_data, 32'hCAFE_F00D);
    check("ready_stays_high", {31'b0, mem_ready}, 32'h1);

    i_rst = 1'b1;
    drive(1'b0, 3'd3, 32'h44, 32'h7777_7777);
    step();
    i_rst = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("rst2_mem_data", mem_data, 32'h0);
    check("rst2_ready", {31'b0, mem_ready}, 32'h0);
    for (int i = 0; i < 100; i++) step();
    check("mid_clear_ready_low", {31'b0, mem_ready}, 32'h0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    wait_ready(n);
    check("reclear_cycles", n, 256);
    do_read(32'h40);
    check("word40_rezeroed", mem_data, 32'h0);
    do_read(32'h44);
    check("word44_untouched", mem_data, 32'h0);
    do_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
